tug_war_referee: RTL and testbench
==================================

// Module: tug_war_referee
// PURPOSE
//   Match controller for the tug-of-war light chain. Conditions the two player keys into
//   single-cycle move pulses L/R, detects a point when the end light is driven off the board,
//   and keeps per-player scores. Drives gameReset to recentre the chain between points and
//   ends the match at WIN_SCORE. Sits between the board keys and the light cells (incl. centre).
// PARAMETERS
//   SCORE_W       3           width of each score counter
//   WIN_SCORE     7           points needed to win the match (1..2**SCORE_W-1)
//   PAUSE_CYCLES  50_000_000  cycles gameReset is held after a point (>=1)
// PORTS
//   Clock       in   1        system clock, all logic on posedge
//   Reset       in   1        synchronous, active-high reset
//   keyL_raw    in   1        left player key, active-high, asynchronous to Clock
//   keyR_raw    in   1        right player key, active-high, asynchronous to Clock
//   lightL_end  in   1        leftmost light of the chain is on
//   lightR_end  in   1        rightmost light of the chain is on
//   difficulty  in   10       CPU press threshold; used only with CPU_PLAYER_EN
//   L           out  1        one-cycle left-move pulse to the light chain
//   R           out  1        one-cycle right-move pulse to the light chain
//   gameReset   out  1        recentre request to the light chain
//   scoreL      out  SCORE_W  left player score
//   scoreR      out  SCORE_W  right player score
//   winner      out  2        00 none, 01 left, 10 right
// BEHAVIOUR
//   Reset, synchronous, active-high; clock Clock.
//   - Reset values: L=R=0, gameReset=0, scoreL=scoreR=0, winner=00, state=PLAY, pause cnt=0.
//     Reset overrides every other event, in any state including mid-pause.
//   - Key path per key: 2-flop synchronizer, then a previous-value register.
//     L and R are registered outputs.
//     - Raw key first sampled high at edge k (low at k-1): move pulse is high from edge k+2
//       to edge k+3, exactly one cycle per press.
//     - A held key gives no further pulses; a new pulse needs a low sample first.
//   - Simultaneous rise: if both key pulses would fire in the same cycle, both L and R are 0.
//   - Masking: L and R are forced to 0 outside PLAY. Edges arriving while masked are dropped,
//     not queued.
//   - Point detection: only in PLAY, evaluated at posedge.
//     - L=1 & lightL_end=1 gives a left point.
//     - R=1 & lightR_end=1 gives a right point.
//     - L and R are never both 1, so points cannot collide.
//   - FSM states: PLAY, PAUSE, OVER.
//   - PLAY: gameReset=0. On a point, increment that score and go to PAUSE with cnt=0.
//     Scores saturate at 2**SCORE_W-1.
//   - PAUSE: gameReset=1. cnt increments each cycle.
//     - When cnt==PAUSE_CYCLES-1: if the just-scored count == WIN_SCORE, set winner and go to
//       OVER; else go to PLAY.
//     - gameReset is high for exactly PAUSE_CYCLES cycles.
//   - OVER: gameReset=1, winner and scores held. Only Reset leaves OVER.
//   - Point-to-output latency: scoreX and gameReset change at the posedge after the qualifying
//     pulse cycle.
// CONFIGURATION
//   CPU_PLAYER_EN
//   - Defined: keyR_raw is ignored; the right player is the CPU.
//     - A 10-bit Fibonacci LFSR (x^10+x^7+1, reset seed 10'h001) steps every cycle.
//     - The CPU "raw key" is (lfsr < difficulty) and feeds the right synchronizer unchanged.
//     - difficulty=0 means the CPU never presses.
//   - Undefined: no LFSR is built; difficulty is ignored; keyR_raw is used.
// TESTING  (bench overrides PAUSE_CYCLES=4, WIN_SCORE=2)
//   1. Reset; keyL_raw high for 10 cycles, lights off -> exactly one L pulse at edge k+2..k+3;
//      R stays 0; scores stay 0.
//   2. lightL_end=1; press L -> scoreL 0->1; gameReset high exactly 4 cycles; L/R 0 throughout;
//      then PLAY with gameReset=0.
//   3. lightL_end=1; keyL_raw and keyR_raw rise in the same cycle -> L=R=0; no score change;
//      gameReset stays 0.
//   4. Two left points -> after the 2nd pause, winner=01, scoreL=2, gameReset stays 1;
//      further presses give no pulses; Reset clears all outputs.
//   5. Reset asserted during PAUSE cycle 2 -> next cycle gameReset=0, scores=0, state PLAY;
//      a new press gives a normal L pulse.
//   6. CPU_PLAYER_EN: difficulty=0 for 1000 cycles -> 0 R pulses; difficulty=512 -> >=1 R pulse;
//      keyR_raw toggling has no effect.

Source files
------------

// File: rtl/tug_war_referee.sv
// tug_war_referee: tug-of-war match controller (key conditioning, scoring, pause/recentre, win); optional CPU right player via CPU_PLAYER_EN
module tug_war_referee #(
    parameter int SCORE_W      = 3,
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_CYCLES = 50_000_000
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               keyL_raw,
    input  logic               keyR_raw,
    input  logic               lightL_end,
    input  logic               lightR_end,
    input  logic [9:0]         difficulty,
    output logic               L,
    output logic               R,
    output logic               gameReset,
    output logic [SCORE_W-1:0] scoreL,
    output logic [SCORE_W-1:0] scoreR,
    output logic [1:0]         winner
);
    localparam int CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);

    typedef enum logic [1:0] {PLAY, PAUSE, OVER} stateType;

    stateType state, nextState;
    logic keyRsrc;
    logic keyLs1, keyLs2, keyLprev;
    logic keyRs1, keyRs2, keyRprev;
    logic riseL, riseR;
    logic pointL, pointR;
    logic lastRight;
    logic [CNT_W-1:0] cnt;

`ifdef CPU_PLAYER_EN
    logic [9:0] lfsr;
    logic unusedKeyR;
    assign unusedKeyR = keyR_raw;
    // CPU press source: x^10+x^7+1 Fibonacci LFSR compared against the difficulty threshold
    always_ff @(posedge Clock) begin
        if (Reset) lfsr <= 10'h001;
        else       lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
    assign keyRsrc = lfsr < difficulty;
`else
    logic unusedDifficulty;
    assign unusedDifficulty = ^difficulty;
    assign keyRsrc = keyR_raw;
`endif

    // two-flop synchronizers plus previous-sample registers for edge detection
    always_ff @(posedge Clock) begin
        if (Reset) begin
            {keyLs1, keyLs2, keyLprev} <= 3'b000;
            {keyRs1, keyRs2, keyRprev} <= 3'b000;
        end else begin
            {keyLs1, keyLs2, keyLprev} <= {keyL_raw, keyLs1, keyLs2};
            {keyRs1, keyRs2, keyRprev} <= {keyRsrc, keyRs1, keyRs2};
        end
    end

    assign riseL = keyLs2 & ~keyLprev;
    assign riseR = keyRs2 & ~keyRprev;
    assign gameReset = state != PLAY;

    // state register
    always_ff @(posedge Clock) begin
        if (Reset) state <= PLAY;
        else       state <= nextState;
    end

    // next-state and point qualification
    always_comb begin
        nextState = state;
        pointL = 1'b0;
        pointR = 1'b0;
        case (state)
            PLAY: begin
                pointL = L & lightL_end;
                pointR = R & lightR_end;
                if (pointL || pointR) nextState = PAUSE;
            end
            PAUSE: begin
                if (cnt == PAUSE_LAST)
                    nextState = ((lastRight ? scoreR : scoreL) == WIN) ? OVER : PLAY;
            end
            default: nextState = OVER;
        endcase
    end

    // move pulses (masked unless next cycle is PLAY), pause counter, scores and winner
    always_ff @(posedge Clock) begin
        if (Reset) begin
            L         <= 1'b0;
            R         <= 1'b0;
            cnt       <= '0;
            scoreL    <= '0;
            scoreR    <= '0;
            winner    <= 2'b00;
            lastRight <= 1'b0;
        end else begin
            L   <= riseL & ~riseR & (nextState == PLAY);
            R   <= riseR & ~riseL & (nextState == PLAY);
            cnt <= (state == PAUSE) ? cnt + 1'b1 : '0;
            if (pointL) begin
                scoreL    <= (scoreL == SCORE_MAX) ? scoreL : scoreL + 1'b1;
                lastRight <= 1'b0;
            end
            if (pointR) begin
                scoreR    <= (scoreR == SCORE_MAX) ? scoreR : scoreR + 1'b1;
                lastRight <= 1'b1;
            end
            if (state == PAUSE && nextState == OVER) winner <= lastRight ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: tb/tb_tug_war_referee.sv
// tb_tug_war_referee: directed self-checking bench for tug_war_referee (PAUSE_CYCLES=4, WIN_SCORE=2)
module tb_tug_war_referee;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic keyL_raw = 1'b0, keyR_raw = 1'b0;
    logic lightL_end = 1'b0, lightR_end = 1'b0;
    logic [9:0] difficulty = 10'd0;
    logic L, R, gameReset;
    logic [2:0] scoreL, scoreR;
    logic [1:0] winner;
    int vectors = 0, miscompares = 0;
    int nL, nR, nG, fL, fG, lrInG;

    tug_war_referee #(.SCORE_W(3), .WIN_SCORE(2), .PAUSE_CYCLES(4)) dut (
        .Clock(Clock), .Reset(Reset), .keyL_raw(keyL_raw), .keyR_raw(keyR_raw),
        .lightL_end(lightL_end), .lightR_end(lightR_end), .difficulty(difficulty),
        .L(L), .R(R), .gameReset(gameReset), .scoreL(scoreL), .scoreR(scoreR), .winner(winner)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ticks n cycles, sampling 1 time unit after each posedge; index i=1 is the first edge
    task automatic run(input int n, output int cl, output int cr, output int cg,
                       output int firstL, output int firstG, output int moveInG);
        cl = 0; cr = 0; cg = 0; firstL = 0; firstG = 0; moveInG = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge Clock); #1;
            if (L) begin cl++; if (firstL == 0) firstL = i; end
            if (R) cr++;
            if (gameReset) begin
                cg++;
                if (firstG == 0) firstG = i;
                if (L || R) moveInG++;
            end
        end
    endtask

    task automatic doReset();
        Reset = 1'b1;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    initial begin
        doReset();
        check("rst_L", L, 0);
        check("rst_R", R, 0);
        check("rst_gameReset", gameReset, 0);
        check("rst_scoreL", scoreL, 0);
        check("rst_scoreR", scoreR, 0);
        check("rst_winner", winner, 0);

        keyL_raw = 1'b1;
        run(10, nL, nR, nG, fL, fG, lrInG);
        check("t1_L_count", nL, 1);
        check("t1_L_pos", fL, 3);
        check("t1_R_count", nR, 0);
        check("t1_scoreL", scoreL, 0);
        keyL_raw = 1'b0;
        run(3, nL, nR, nG, fL, fG, lrInG);

        lightL_end = 1'b1;
        keyL_raw = 1'b1;
        run(12, nL, nR, nG, fL, fG, lrInG);
        check("t2_L_pos", fL, 3);
        check("t2_L_count", nL, 1);
        check("t2_gr_first", fG, 4);
        check("t2_gr_len", nG, 4);
        check("t2_move_in_pause", lrInG, 0);
        check("t2_scoreL", scoreL, 1);
        check("t2_gr_after", gameReset, 0);
        keyL_raw = 1'b0;
        run(3, nL, nR, nG, fL, fG, lrInG);

`ifndef CPU_PLAYER_EN
        keyL_raw = 1'b1;
        keyR_raw = 1'b1;
        run(6, nL, nR, nG, fL, fG, lrInG);
        check("t3_L_count", nL, 0);
        check("t3_R_count", nR, 0);
        check("t3_gr_count", nG, 0);
        check("t3_scoreL", scoreL, 1);
        keyL_raw = 1'b0;
        keyR_raw = 1'b0;
        run(3, nL, nR, nG, fL, fG, lrInG);

        lightL_end = 1'b0;
        lightR_end = 1'b1;
        keyR_raw = 1'b1;
        run(12, nL, nR, nG, fL, fG, lrInG);
        check("tR_R_count", nR, 1);
        check("tR_gr_len", nG, 4);
        check("tR_scoreR", scoreR, 1);
        check("tR_scoreL", scoreL, 1);
        keyR_raw = 1'b0;
        lightR_end = 1'b0;
        run(3, nL, nR, nG, fL, fG, lrInG);
`endif

        doReset();
        lightL_end = 1'b1;
        for (int p = 1; p <= 2; p++) begin
            keyL_raw = 1'b1;
            run(12, nL, nR, nG, fL, fG, lrInG);
            keyL_raw = 1'b0;
            run(3, nL, nR, nG, fL, fG, lrInG);
            check("t4_scoreL", scoreL, p);
            check("t4_winner", winner, (p == 2) ? 1 : 0);
            check("t4_gr", gameReset, (p == 2) ? 1 : 0);
        end
        keyL_raw = 1'b1;
        run(8, nL, nR, nG, fL, fG, lrInG);
        check("t4_over_L", nL, 0);
        check("t4_over_gr", nG, 8);
        keyL_raw = 1'b0;
        run(3, nL, nR, nG, fL, fG, lrInG);
`ifndef CPU_PLAYER_EN
        keyR_raw = 1'b1;
        run(8, nL, nR, nG, fL, fG, lrInG);
        check("t4_over_R", nR, 0);
        keyR_raw = 1'b0;
        run(3, nL, nR, nG, fL, fG, lrInG);
`endif
        check("t4_over_winner", winner, 1);
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check("t4_rst_winner", winner, 0);
        check("t4_rst_scoreL", scoreL, 0);
        check("t4_rst_gr", gameReset, 0);

        keyL_raw = 1'b1;
        run(5, nL, nR, nG, fL, fG, lrInG);
        check("t5_gr_first", fG, 4);
        check("t5_gr_count", nG, 2);
        Reset = 1'b1;
        keyL_raw = 1'b0;
        lightL_end = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check("t5_gr", gameReset, 0);
        check("t5_scoreL", scoreL, 0);
        check("t5_scoreR", scoreR, 0);
        run(3, nL, nR, nG, fL, fG, lrInG);
        check("t5_still_play", nG, 0);
        keyL_raw = 1'b1;
        run(6, nL, nR, nG, fL, fG, lrInG);
        check("t5_L_count", nL, 1);
        check("t5_L_pos", fL, 3);
        keyL_raw = 1'b0;
        run(3, nL, nR, nG, fL, fG, lrInG);

`ifdef CPU_PLAYER_EN
        begin
            int cpuR;
            cpuR = 0;
            difficulty = 10'd0;
            for (int i = 0; i < 1000; i++) begin
                keyR_raw = i[0];
                @(posedge Clock); #1;
                if (R) cpuR++;
            end
            check("t6_cpu_none", cpuR, 0);
            cpuR = 0;
            difficulty = 10'd512;
            for (int i = 0; i < 1000; i++) begin
                keyR_raw = i[1];
                @(posedge Clock); #1;
                if (R) cpuR++;
            end
            check("t6_cpu_some", (cpuR >= 1) ? 1 : 0, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
